interval_counter: RTL and testbench



---
 rtl/interval_counter_if.sv | 16 +
 rtl/interval_counter.sv | 56 +++++
 tb/tb_interval_counter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/interval_counter_if.sv
// interval_counter_if: control and status bundle for interval_counter.
interface interval_counter_if #(parameter int WIDTH = 17);
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic             counting;
  logic             paused;
  logic             done;
  logic [WIDTH-1:0] result;
  modport master (output start, stop, pause, periodic, limit,
                  input  counting, paused, done, result);
  modport slave  (input  start, stop, pause, periodic, limit,
                  output counting, paused, done, result);
endinterface

// File: rtl/interval_counter.sv
// interval_counter: counts 0..limit-1 after start, one-shot or periodic, with pause/abort/retrigger.
module interval_counter #(parameter int WIDTH = 17) (
  input logic              clk,
  input logic              reset,
  interval_counter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t           state;
  logic [WIDTH-1:0] lim_q;
  logic             per_q;
  logic             go;
  logic             last;
  assign go   = bus.start && (bus.limit != '0);
  assign last = bus.result == lim_q - WIDTH'(1);
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lim_q        <= '0;
      per_q        <= 1'b0;
      bus.counting <= 1'b0;
      bus.paused   <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.stop) begin
        state        <= IDLE;
        bus.counting <= 1'b0;
        bus.paused   <= 1'b0;
        bus.result   <= '0;
      end else if (go) begin
        lim_q        <= bus.limit;
        per_q        <= bus.periodic;
        bus.result   <= '0;
        state        <= bus.pause ? HOLD : RUN;
        bus.counting <= 1'b1;
        bus.paused   <= bus.pause;
      end else if (state == RUN && bus.pause) begin
        state      <= HOLD;
        bus.paused <= 1'b1;
      end else if (state == RUN && last) begin
        bus.done   <= 1'b1;
        bus.result <= '0;
        if (!per_q) begin
          state        <= IDLE;
          bus.counting <= 1'b0;
        end
      end else if (state == RUN) begin
        bus.result <= bus.result + WIDTH'(1);
      end else if (state == HOLD && !bus.pause) begin
        state      <= RUN;
        bus.paused <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_interval_counter.sv
// tb_interval_counter: directed scenario tests for interval_counter.
module tb_interval_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  interval_counter_if #(.WIDTH(17)) b ();
  interval_counter_if #(.WIDTH(10)) s ();
  interval_counter #(.WIDTH(17)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  interval_counter #(.WIDTH(10)) dut_s (.clk(clk), .reset(reset), .bus(s.slave));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [19:0] obs();
    return {b.counting, b.paused, b.done, b.result};
  endfunction
  function automatic logic [19:0] ex(input logic c, input logic p, input logic d, input int r);
    return {c, p, d, 17'(r)};
  endfunction
  task automatic test_reset();
    logic [19:0] e;
    reset = 1'b1;
    step();
    e = ex(0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL reset: got %h expected %h", obs(), e); end
    reset = 1'b0;
  endtask
  task automatic test_oneshot();
    logic [19:0] e;
    b.limit = 17'd5; b.periodic = 1'b0; b.start = 1'b1;
    step();
    b.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = ex(1, 0, 0, i);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL oneshot_%0d: got %h expected %h", i, obs(), e); end
      step();
    end
    e = ex(0, 0, 1, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL oneshot_done: got %h expected %h", obs(), e); end
    step();
    e = ex(0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL oneshot_after: got %h expected %h", obs(), e); end
  endtask
  task automatic test_periodic();
    logic [19:0] e;
    b.limit = 17'd3; b.periodic = 1'b1; b.start = 1'b1;
    step();
    b.start = 1'b0; b.periodic = 1'b0;
    e = ex(1, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL periodic_0: got %h expected %h", obs(), e); end
    for (int c = 1; c <= 9; c++) begin
      step();
      e = ex(1, 0, (c % 3) == 0, c % 3);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL periodic_%0d: got %h expected %h", c, obs(), e); end
    end
    b.stop = 1'b1;
    step();
    b.stop = 1'b0;
    e = ex(0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL periodic_stop: got %h expected %h", obs(), e); end
  endtask
  task automatic test_pause();
    logic [19:0] e;
    b.limit = 17'd4; b.start = 1'b1;
    step();
    b.start = 1'b0;
    step();
    step();
    b.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = ex(1, 1, 0, 2);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL pause_hold_%0d: got %h expected %h", i, obs(), e); end
    end
    b.pause = 1'b0;
    step();
    e = ex(1, 0, 0, 2);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL pause_resume: got %h expected %h", obs(), e); end
    step();
    e = ex(1, 0, 0, 3);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL pause_count: got %h expected %h", obs(), e); end
    step();
    e = ex(0, 0, 1, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL pause_done: got %h expected %h", obs(), e); end
  endtask
  task automatic test_retrigger();
    logic [19:0] e;
    b.limit = 17'd10; b.start = 1'b1;
    step();
    b.start = 1'b0;
    repeat (6) step();
    e = ex(1, 0, 0, 6);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL retrig_pre: got %h expected %h", obs(), e); end
    b.limit = 17'd3; b.start = 1'b1;
    step();
    b.start = 1'b0; b.limit = 17'd9;
    for (int i = 0; i < 3; i++) begin
      e = ex(1, 0, 0, i);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL retrig_%0d: got %h expected %h", i, obs(), e); end
      step();
    end
    e = ex(0, 0, 1, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL retrig_done: got %h expected %h", obs(), e); end
  endtask
  task automatic test_terminal();
    logic [19:0] e;
    b.limit = 17'd2; b.start = 1'b1;
    step();
    b.start = 1'b0;
    step();
    b.stop = 1'b1;
    step();
    b.stop = 1'b0;
    e = ex(0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL stop_terminal: got %h expected %h", obs(), e); end
    b.start = 1'b1;
    step();
    b.start = 1'b0;
    step();
    b.limit = 17'd3; b.start = 1'b1;
    step();
    b.start = 1'b0;
    e = ex(1, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL start_terminal: got %h expected %h", obs(), e); end
    b.stop = 1'b1;
    step();
    b.stop = 1'b0;
  endtask
  task automatic test_edges();
    logic [19:0] e;
    b.limit = 17'd0; b.start = 1'b1;
    step();
    b.start = 1'b0;
    e = ex(0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL limit0: got %h expected %h", obs(), e); end
    b.limit = 17'd1; b.start = 1'b1;
    step();
    b.start = 1'b0;
    e = ex(1, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL limit1_run: got %h expected %h", obs(), e); end
    step();
    e = ex(0, 0, 1, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL limit1_done: got %h expected %h", obs(), e); end
    b.limit = 17'h1FFFF; b.pause = 1'b1; b.start = 1'b1;
    step();
    b.start = 1'b0; b.pause = 1'b0;
    e = ex(1, 1, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL start_paused: got %h expected %h", obs(), e); end
    b.stop = 1'b1;
    step();
    b.stop = 1'b0;
  endtask
  task automatic test_max();
    s.limit = 10'h3FF; s.start = 1'b1;
    step();
    s.start = 1'b0;
    repeat (1022) step();
    total++;
    if ({s.counting, s.done, s.result} !== {1'b1, 1'b0, 10'd1022}) begin
      bad++; $display("FAIL max_last: got %h expected %h", {s.counting, s.done, s.result}, {1'b1, 1'b0, 10'd1022});
    end
    step();
    total++;
    if ({s.counting, s.done, s.result} !== {1'b0, 1'b1, 10'd0}) begin
      bad++; $display("FAIL max_done: got %h expected %h", {s.counting, s.done, s.result}, {1'b0, 1'b1, 10'd0});
    end
  endtask
  task automatic test_reset_mid();
    logic [19:0] e;
    b.limit = 17'd10; b.start = 1'b1;
    step();
    b.start = 1'b0;
    repeat (7) step();
    e = ex(1, 0, 0, 7);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_pre: got %h expected %h", obs(), e); end
    reset = 1'b1; b.start = 1'b1;
    step();
    reset = 1'b0; b.start = 1'b0;
    e = ex(0, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_edge: got %h expected %h", obs(), e); end
    repeat (3) step();
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_idle: got %h expected %h", obs(), e); end
    b.limit = 17'd2; b.start = 1'b1;
    step();
    b.start = 1'b0;
    e = ex(1, 0, 0, 0);
    total++;
    if (obs() !== e) begin bad++; $display("FAIL rstmid_fresh: got %h expected %h", obs(), e); end
  endtask
  initial begin
    b.start = 1'b0; b.stop = 1'b0; b.pause = 1'b0; b.periodic = 1'b0; b.limit = '0;
    s.start = 1'b0; s.stop = 1'b0; s.pause = 1'b0; s.periodic = 1'b0; s.limit = '0;
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_retrigger();
    test_terminal();
    test_edges();
    test_max();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
